// File: rtl/ram_dp_ctrl_if.sv
// ram_dp_ctrl_if -- access bus of the dual-port RAM controller.
//   clr      : synchronous clear request (one-cycle pulse)
//   ready    : array initialised, accesses accepted
//   we/waddr/wdata/be : write port with byte-lane enables
//   re/raddr          : read request
//   rdata/rvalid      : read response, rvalid is a one-cycle strobe
//   par_flip/rperr    : parity error injection / report (RAM_PARITY_EN only)
// master = controller / loader side, slave = the RAM.
interface ram_dp_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  localparam int LANES = DATA_W / 8;

  logic              clr;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [LANES-1:0]  be;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
`ifdef RAM_PARITY_EN
  logic              par_flip;
  logic              rperr;

  modport master (
    output clr, we, waddr, wdata, be, re, raddr, par_flip,
    input  ready, rdata, rvalid, rperr
  );
  modport slave (
    input  clr, we, waddr, wdata, be, re, raddr, par_flip,
    output ready, rdata, rvalid, rperr
  );
`else
  modport master (
    output clr, we, waddr, wdata, be, re, raddr,
    input  ready, rdata, rvalid
  );
  modport slave (
    input  clr, we, waddr, wdata, be, re, raddr,
    output ready, rdata, rvalid
  );
`endif
endinterface

// File: rtl/ram_dp_ctrl.sv
// ram_dp_ctrl -- parametrised simple-dual-port synchronous RAM.
//   clk   : clock, everything on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_dp_ctrl_if.slave (write port, read port, clr, ready)
// A clear FSM zeroes the array after reset and on clr; while it runs
// ready=0 and all accesses are ignored. Reads are write-first on a same-
// cycle address match; out-of-range reads return 0 with rvalid.
// READ_LAT is 1 or 2 (2 adds an output register stage).
// Optional macro RAM_PARITY_EN: per-lane even parity storage, par_flip
// error injection on writes and rperr reporting on reads.
module ram_dp_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_dp_ctrl_if.slave bus
);
  localparam int LANES = DATA_W / 8;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rdy;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
  logic [LANES-1:0]  par [DEPTH];
  logic [LANES-1:0]  wpar, mpar;
  logic              rd_perr;
`endif

  logic              clr_go, w_in, r_in, wr_acc, rd_acc, fwd;
  logic [DATA_W-1:0] be_mask, mem_rd, rd_word;

  // clr only matters once the array is live; a clr during clearing is ignored
  assign clr_go = rdy & bus.clr;
  assign w_in   = {1'b0, bus.waddr} < (ADDR_W+1)'(DEPTH);
  assign r_in   = {1'b0, bus.raddr} < (ADDR_W+1)'(DEPTH);
  // clr beats a same-cycle write or read
  assign wr_acc = rdy & ~bus.clr & bus.we & w_in;
  assign rd_acc = rdy & ~bus.clr & bus.re;
  assign fwd    = wr_acc & r_in & (bus.waddr == bus.raddr);

  assign mem_rd = mem[bus.raddr];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign be_mask[8*i +: 8] = {8{bus.be[i]}};
`ifdef RAM_PARITY_EN
    assign wpar[i] = (^bus.wdata[8*i +: 8]) ^ bus.par_flip;
    assign mpar[i] = ^mem_rd[8*i +: 8];
`endif
  end

  // write-first: enabled lanes of a colliding write replace the old contents
  always_comb begin
    rd_word = '0;
    if (r_in) rd_word = fwd ? ((mem_rd & ~be_mask) | (bus.wdata & be_mask)) : mem_rd;
  end

`ifdef RAM_PARITY_EN
  // a forwarded word is freshly built, its parity is consistent by definition
  always_comb begin
    rd_perr = 1'b0;
    if (r_in && !fwd) rd_perr = |(par[bus.raddr] ^ mpar);
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= S_RUN;
            rdy   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.clr) begin
            state <= S_CLEAR;
            rdy   <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_CLEAR;
          rdy   <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- array
  // No reset on the storage so it maps onto RAM macros; the clear FSM
  // provides the defined contents.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
`ifdef RAM_PARITY_EN
      par[cnt] <= '0;
`endif
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.be[i]) begin
          mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
`ifdef RAM_PARITY_EN
          par[bus.waddr][i] <= wpar[i];
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------- read pipe
  // vld_pipe[READ_LAT] is rvalid. A clr kills every read still in the
  // pipe; the final data stage only loads on a surviving read so rdata
  // holds its last value otherwise.
  logic [READ_LAT:1]             vld_pipe;
  logic [READ_LAT:1][DATA_W-1:0] dpipe;
`ifdef RAM_PARITY_EN
  logic [READ_LAT:1]             ppipe;
`endif

  if (READ_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        dpipe    <= '0;
`ifdef RAM_PARITY_EN
        ppipe    <= '0;
`endif
      end else begin
        vld_pipe <= {vld_pipe[1] & ~clr_go, rd_acc};
        if (rd_acc) begin
          dpipe[1] <= rd_word;
`ifdef RAM_PARITY_EN
          ppipe[1] <= rd_perr;
`endif
        end
        if (vld_pipe[1] && !clr_go) begin
          dpipe[2] <= dpipe[1];
`ifdef RAM_PARITY_EN
          ppipe[2] <= ppipe[1];
`endif
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        dpipe    <= '0;
`ifdef RAM_PARITY_EN
        ppipe    <= '0;
`endif
      end else begin
        vld_pipe <= rd_acc;
        if (rd_acc) begin
          dpipe[1] <= rd_word;
`ifdef RAM_PARITY_EN
          ppipe[1] <= rd_perr;
`endif
        end
      end
    end
  end

  assign bus.ready  = rdy;
  assign bus.rvalid = vld_pipe[READ_LAT];
  assign bus.rdata  = dpipe[READ_LAT];
`ifdef RAM_PARITY_EN
  assign bus.rperr  = vld_pipe[READ_LAT] & ppipe[READ_LAT];
`endif

endmodule

// File: tb/tb_ram_dp_ctrl.sv
// Two instances share one stimulus stream: A (DEPTH 256, READ_LAT 2) and
// B (DEPTH 200, READ_LAT 1). Each has its own reference model and queue
// of expected read responses.
module tb_ram_dp_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clr, we, re, pflip;
  logic [1:0]  be;
  logic [7:0]  waddr, raddr;
  logic [15:0] wdata;

  ram_dp_ctrl_if #(.DATA_W(16), .ADDR_W(8)) ia ();
  ram_dp_ctrl_if #(.DATA_W(16), .ADDR_W(8)) ib ();

  assign ia.clr = clr;     assign ib.clr = clr;
  assign ia.we = we;       assign ib.we = we;
  assign ia.waddr = waddr; assign ib.waddr = waddr;
  assign ia.wdata = wdata; assign ib.wdata = wdata;
  assign ia.be = be;       assign ib.be = be;
  assign ia.re = re;       assign ib.re = re;
  assign ia.raddr = raddr; assign ib.raddr = raddr;
`ifdef RAM_PARITY_EN
  assign ia.par_flip = pflip;
  assign ib.par_flip = pflip;
`endif

  ram_dp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .READ_LAT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  ram_dp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .READ_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  localparam int DEP [2] = '{256, 200};
  localparam int LAT [2] = '{2, 1};

  typedef struct {
    int          acc;
    int          due;
    logic [15:0] d;
    logic        pe;
  } exp_t;

  exp_t        q [2][$];
  logic [15:0] mm [2][256];
  logic [1:0]  pb [2][256];
  bit          rdy_m [2];
  int          cnt_m [2];
  logic [15:0] last [2];
  int          n_vec = 0, n_err = 0, cyc = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      rdy_m[k] = 1'b0;
      cnt_m[k] = 0;
      last[k]  = '0;
      q[k].delete();
      for (int a = 0; a < 256; a++) begin
        mm[k][a] = '0;
        pb[k][a] = '0;
      end
    end
  endfunction

  // Reference behaviour of one instance at the coming rising edge.
  function automatic void model_edge(int k);
    int          e = cyc + 1;
    logic [15:0] m, old;
    exp_t        x;
    m = {{8{be[1]}}, {8{be[0]}}};
    if (!rdy_m[k]) begin
      cnt_m[k]++;
      if (cnt_m[k] == DEP[k]) rdy_m[k] = 1'b1;
    end else if (clr) begin
      rdy_m[k] = 1'b0;
      cnt_m[k] = 0;
      for (int a = 0; a < 256; a++) begin
        mm[k][a] = '0;
        pb[k][a] = '0;
      end
      while (q[k].size() > 0 && q[k][$].acc > e - LAT[k]) void'(q[k].pop_back());
    end else begin
      if (re) begin
        x.acc = e;
        x.due = e + LAT[k] - 1;
        x.d   = '0;
        x.pe  = 1'b0;
        if (int'(raddr) < DEP[k]) begin
          old  = mm[k][raddr];
          x.d  = old;
          x.pe = |pb[k][raddr];
          if (we && waddr == raddr) begin
            x.d  = (old & ~m) | (wdata & m);
            x.pe = 1'b0;
          end
        end
        q[k].push_back(x);
      end
      if (we && int'(waddr) < DEP[k]) begin
        mm[k][waddr] = (mm[k][waddr] & ~m) | (wdata & m);
        for (int i = 0; i < 2; i++) if (be[i]) pb[k][waddr][i] = pflip;
      end
    end
  endfunction

  function automatic void get_out(int k, output logic r, output logic v,
                                  output logic [15:0] d, output logic pe);
    pe = 1'b0;
    if (k == 0) begin
      r = ia.ready; v = ia.rvalid; d = ia.rdata;
`ifdef RAM_PARITY_EN
      pe = ia.rperr;
`endif
    end else begin
      r = ib.ready; v = ib.rvalid; d = ib.rdata;
`ifdef RAM_PARITY_EN
      pe = ib.rperr;
`endif
    end
  endfunction

  task automatic check_out(int k);
    logic        r, v, pe;
    logic [15:0] d;
    exp_t        x;
    string       nm;
    nm = (k == 0) ? "A" : "B";
    get_out(k, r, v, d, pe);
    chk({nm, ".ready"}, r, rdy_m[k]);
    if (q[k].size() > 0 && q[k][0].due == cyc) begin
      x = q[k].pop_front();
      chk({nm, ".rvalid"}, v, 1);
      chk({nm, ".rdata"}, d, x.d);
      last[k] = x.d;
`ifdef RAM_PARITY_EN
      chk({nm, ".rperr"}, pe, x.pe);
`endif
    end else begin
      chk({nm, ".rvalid_idle"}, v, 0);
      chk({nm, ".rdata_hold"}, d, last[k]);
`ifdef RAM_PARITY_EN
      chk({nm, ".rperr_idle"}, pe, 0);
`endif
    end
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) model_edge(k);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) check_out(k);
  endtask

  task automatic quiet();
    clr = 0; we = 0; re = 0; pflip = 0; be = 2'b11;
  endtask

  task automatic idle(int n);
    quiet();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready();
    int n = 0;
    quiet();
    while (!(rdy_m[0] && rdy_m[1]) && n < 1000) begin
      step();
      n++;
    end
    chk("ready_bound", {31'd0, rdy_m[0] & rdy_m[1]}, 1);
  endtask

  task automatic wr(logic [7:0] a, logic [15:0] d, logic [1:0] b, logic f);
    quiet();
    we = 1; waddr = a; wdata = d; be = b; pflip = f;
    step();
    quiet();
  endtask

  task automatic rd(logic [7:0] a);
    quiet();
    re = 1; raddr = a;
    step();
    quiet();
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, ".A.ready"}, ia.ready, 0);
    chk({tag, ".A.rvalid"}, ia.rvalid, 0);
    chk({tag, ".A.rdata"}, ia.rdata, 0);
    chk({tag, ".B.ready"}, ib.ready, 0);
    chk({tag, ".B.rvalid"}, ib.rvalid, 0);
    chk({tag, ".B.rdata"}, ib.rdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    quiet();
    waddr = '0; raddr = '0; wdata = '0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1;

    // accesses during clearing are ignored
    for (int i = 0; i < 60; i++) begin
      we = 1; re = 1; be = 2'b11;
      waddr = 8'($urandom); raddr = 8'($urandom); wdata = 16'($urandom);
      step();
    end

    // reset in the middle of clearing restarts it from address 0
    quiet();
    rst_n = 0;
    #1;
    chk_reset_outs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 150; i++) begin
      we = 1; re = 1; be = 2'b11;
      waddr = 8'($urandom); raddr = 8'($urandom); wdata = 16'($urandom);
      step();
    end
    wait_ready();

    // every address reads back zero, back-to-back
    for (int a = 0; a < 256; a++) begin
      re = 1; raddr = 8'(a);
      step();
    end
    idle(3);

    // byte lanes
    wr(8'h10, 16'hBEEF, 2'b11, 0);
    wr(8'h10, 16'h12AB, 2'b10, 0);
    wr(8'h10, 16'hFFFF, 2'b00, 0);
    rd(8'h10);
    idle(3);

    // write-first collision
    wr(8'h20, 16'hAAAA, 2'b11, 0);
    quiet();
    we = 1; waddr = 8'h20; wdata = 16'h5555; be = 2'b01;
    re = 1; raddr = 8'h20;
    step();
    rd(8'h20);
    idle(3);

    // address boundary (B has DEPTH 200)
    wr(8'hC8, 16'h1234, 2'b11, 0);
    rd(8'hC8);
    wr(8'hC7, 16'h5678, 2'b11, 0);
    rd(8'hC7);
    idle(3);

`ifdef RAM_PARITY_EN
    wr(8'h05, 16'h00FF, 2'b11, 1);
    rd(8'h05);
    idle(3);
    wr(8'h05, 16'h00FF, 2'b11, 0);
    rd(8'h05);
    idle(3);
`endif

    // random traffic around the boundary and a low window
    for (int i = 0; i < 400; i++) begin
      quiet();
      we = 1'($urandom); re = 1'($urandom); be = 2'($urandom);
      waddr = ($urandom_range(1) != 0) ? 8'(8'hC0 + $urandom_range(15)) : 8'($urandom_range(15));
      raddr = ($urandom_range(3) == 0) ? waddr
            : (($urandom_range(1) != 0) ? 8'(8'hC0 + $urandom_range(15)) : 8'($urandom_range(15)));
      wdata = 16'($urandom);
      pflip = ($urandom_range(7) == 0);
      step();
    end
    idle(3);

    // clr with reads in flight; the same-cycle write is dropped
    for (int i = 0; i < 8; i++) begin
      quiet();
      re = 1; raddr = 8'(8'h10 + i);
      if (i == 4) begin
        clr = 1; we = 1; waddr = 8'h10; wdata = 16'hDEAD; be = 2'b11;
      end
      step();
    end
    wait_ready();
    for (int a = 0; a < 256; a++) begin
      re = 1; raddr = 8'(a);
      step();
    end
    idle(3);

    // asynchronous reset with live read data
    wr(8'h33, 16'hCAFE, 2'b11, 0);
    rd(8'h33);
    rst_n = 0;
    #1;
    chk_reset_outs("rst_async");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
